// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low {a,b,c,d,e,f,g} with a in the MSB.
//
// Optional feature macro: SEVSEG_HEX_EN (enables the A-F glyphs in the
// decoder; the constants are always present here).
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (active-low).
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;

    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

endpackage

// File: rtl/sev_seg_decoder.sv
// sev_seg_decoder
// Combinational 4-bit code to active-low seven-segment glyph.
//
// Ports:
//   code   in  4  digit code
//   seg    out 7  active-low {a,b,c,d,e,f,g}
//   valid  out 1  1 = code has a glyph; 0 = caller should darken the digit
//
// Optional feature macro: SEVSEG_HEX_EN. When defined, codes 10-15 decode
// to A,b,C,d,E,F; otherwise they are reported invalid with a blank glyph.
module sev_seg_decoder
    import sev_seg_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       seg,
    output logic       valid
);

    always_comb begin
        seg   = SEG_BLANK;
        valid = 1'b1;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SEVSEG_HEX_EN
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            default: seg = SEG_F;
`else
            default: begin
                seg   = SEG_BLANK;
                valid = 1'b0;
            end
`endif
        endcase
    end

endmodule

// File: rtl/sev_seg_scan_mux.sv
// sev_seg_scan_mux
// Time-multiplexed N-digit seven-segment driver with its own refresh scan.
// Each digit owns a slot of REFRESH_DIV clocks; the first GHOST_CYC clocks
// of every slot keep all anodes off so the previous digit cannot ghost.
// All outputs are registered: the value shown in cycle t+1 is derived from
// the prescaler, slot, blink phase and live inputs of cycle t.
//
// Ports:
//   clk            in   1            system clock
//   rst_n          in   1            asynchronous active-low reset
//   enable         in   1            0 = dark, scan parked at slot 0
//   digits_bcd     in   4*NUM_DIGITS digit i at [4i+3:4i], digit 0 rightmost
//   dp_mask        in   NUM_DIGITS   1 = light decimal point of digit i
//   blank_mask     in   NUM_DIGITS   1 = digit i dark
//   blink_mask     in   NUM_DIGITS   1 = digit i dark while blink phase = 1
//   blink_tick     in   1            single-cycle pulse, toggles blink phase
//   segment        out  7            active-low {a..g}, MSB = a
//   anodes         out  NUM_DIGITS   active-low digit select
//   decimal_point  out  1            active-low
//   digit_sel      out  SEL_W        slot index shown this cycle
//   frame_done     out  1            pulse after slot wraps NUM_DIGITS-1 -> 0
//
// Optional feature macro: SEVSEG_HEX_EN (hex glyphs for codes 10-15,
// handled inside sev_seg_decoder).
module sev_seg_scan_mux
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 2
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             enable,
    input  logic [4*NUM_DIGITS-1:0]                          digits_bcd,
    input  logic [NUM_DIGITS-1:0]                            dp_mask,
    input  logic [NUM_DIGITS-1:0]                            blank_mask,
    input  logic [NUM_DIGITS-1:0]                            blink_mask,
    input  logic                                             blink_tick,
    output logic [6:0]                                       segment,
    output logic [NUM_DIGITS-1:0]                            anodes,
    output logic                                             decimal_point,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
    output logic                                             frame_done
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (NUM_DIGITS < 1 || GHOST_CYC < 0 || REFRESH_DIV <= GHOST_CYC) begin : g_bad_params
            $error("sev_seg_scan_mux: illegal parameters (need NUM_DIGITS>=1, GHOST_CYC>=0, REFRESH_DIV>GHOST_CYC)");
        end
    endgenerate

    // Scan state
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [SEL_W-1:0]      slot_q, slot_d;
    logic                  phase_q, phase_d;

    // Registered outputs
    seg_t                  segment_q, segment_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic                  dp_q, dp_d;
    logic [SEL_W-1:0]      digit_sel_q, digit_sel_d;
    logic                  frame_done_q, frame_done_d;

    // Current-slot view of the inputs
    logic [3:0]            cur_code;
    seg_t                  dec_seg;
    logic                  dec_valid;
    logic                  cur_dark;
    logic                  last_presc;
    logic                  last_slot;
    logic                  in_ghost;

    assign cur_code   = digits_bcd[{slot_q, 2'b00} +: 4];
    assign last_presc = (presc_q == PRE_W'(REFRESH_DIV - 1));
    assign last_slot  = (slot_q == SEL_W'(NUM_DIGITS - 1));
    assign in_ghost   = (presc_q < PRE_W'(GHOST_CYC));

    sev_seg_decoder u_decoder (
        .code  (cur_code),
        .seg   (dec_seg),
        .valid (dec_valid)
    );

    // Blink gating uses the phase as it stands in this cycle, so a tick
    // changes the displayed digit one cycle after the phase flop updates.
    assign cur_dark = blank_mask[slot_q]
                    | (blink_mask[slot_q] & phase_q)
                    | ~dec_valid;

    always_comb begin
        // Blink phase runs regardless of enable.
        phase_d      = phase_q ^ blink_tick;

        // Defaults describe the disabled display: parked at slot 0, dark.
        presc_d      = '0;
        slot_d       = '0;
        frame_done_d = 1'b0;
        anodes_d     = '1;
        segment_d    = SEG_BLANK;
        dp_d         = 1'b1;
        digit_sel_d  = '0;

        if (enable) begin
            if (last_presc) begin
                presc_d = '0;
                slot_d  = last_slot ? '0 : slot_q + SEL_W'(1);
            end else begin
                presc_d = presc_q + PRE_W'(1);
                slot_d  = slot_q;
            end

            frame_done_d = last_presc & last_slot;
            digit_sel_d  = slot_q;

            // Dead-time at the start of every slot; a dark digit still scans.
            if (!in_ghost) begin
                anodes_d = ~(NUM_DIGITS'(1) << slot_q);
            end

            if (!cur_dark) begin
                segment_d = dec_seg;
                dp_d      = ~dp_mask[slot_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            slot_q       <= '0;
            phase_q      <= 1'b0;
            segment_q    <= SEG_BLANK;
            anodes_q     <= '1;
            dp_q         <= 1'b1;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            phase_q      <= phase_d;
            segment_q    <= segment_d;
            anodes_q     <= anodes_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment       = segment_q;
    assign anodes        = anodes_q;
    assign decimal_point = dp_q;
    assign digit_sel     = digit_sel_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_mux.sv
// tb_sev_seg_scan_mux
// Directed bench for sev_seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4,
// GHOST_CYC=1. A behavioural model derived from an elapsed-cycle counter
// predicts each registered output word; predictions are queued when the
// inputs are driven and compared one cycle later.
// Optional feature macro: SEVSEG_HEX_EN (changes the expected glyph of 4'hB).
module tb_sev_seg_scan_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [15:0]   digits_bcd;
    logic [3:0]    dp_mask;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic          blink_tick;
    logic [6:0]    segment;
    logic [3:0]    anodes;
    logic          decimal_point;
    logic [1:0]    digit_sel;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // {frame_done, digit_sel, decimal_point, anodes, segment}
    logic [14:0] exp_q[$];

    // Model state: cycles elapsed in the enabled scan, and blink phase.
    int tick  = 0;
    bit phase = 1'b0;

    sev_seg_scan_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GHOST_CYC   (GC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .digits_bcd    (digits_bcd),
        .dp_mask       (dp_mask),
        .blank_mask    (blank_mask),
        .blink_mask    (blink_mask),
        .blink_tick    (blink_tick),
        .segment       (segment),
        .anodes        (anodes),
        .decimal_point (decimal_point),
        .digit_sel     (digit_sel),
        .frame_done    (frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ok, glyph} straight from the segment table
    function automatic logic [7:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return {1'b1, 7'b0000001};
            4'd1: return {1'b1, 7'b1001111};
            4'd2: return {1'b1, 7'b0010010};
            4'd3: return {1'b1, 7'b0000110};
            4'd4: return {1'b1, 7'b1001100};
            4'd5: return {1'b1, 7'b0100100};
            4'd6: return {1'b1, 7'b0100000};
            4'd7: return {1'b1, 7'b0001111};
            4'd8: return {1'b1, 7'b0000000};
            4'd9: return {1'b1, 7'b0000100};
`ifdef SEVSEG_HEX_EN
            4'd10: return {1'b1, 7'b0001000};
            4'd11: return {1'b1, 7'b1100000};
            4'd12: return {1'b1, 7'b0110001};
            4'd13: return {1'b1, 7'b1000010};
            4'd14: return {1'b1, 7'b0110000};
            default: return {1'b1, 7'b0111000};
`else
            default: return {1'b0, 7'b1111111};
`endif
        endcase
    endfunction

    function automatic logic [14:0] model_out();
        int presc, slot;
        logic [3:0] an;
        logic [7:0] g;
        logic dark, dp, fd;
        if (!enable) return {1'b0, 2'b00, 1'b1, 4'hF, 7'h7F};
        presc = tick % RD;
        slot  = (tick / RD) % ND;
        an    = (presc < GC) ? 4'hF : ~(4'b0001 << slot);
        g     = glyph(digits_bcd[slot*4 +: 4]);
        dark  = blank_mask[slot] | (blink_mask[slot] & phase) | ~g[7];
        dp    = dark ? 1'b1 : ~dp_mask[slot];
        fd    = (presc == RD - 1) && (slot == ND - 1);
        return {fd, 2'(slot), dp, an, dark ? 7'h7F : g[6:0]};
    endfunction

    // One clock: predict from the current inputs, advance the model,
    // then compare the DUT's registered outputs just after the edge.
    task automatic step();
        logic [14:0] e;
        exp_q.push_back(model_out());
        tick  = enable ? (tick + 1) % (ND * RD) : 0;
        phase = phase ^ blink_tick;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("scan_word", {17'd0, frame_done, digit_sel, decimal_point, anodes, segment}, {17'd0, e});
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {frame_done, digit_sel, decimal_point, anodes, segment},
              {1'b0, 2'b00, 1'b1, 4'hF, 7'h7F});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fd_count;
        int guard;
        rst_n      = 1'b0;
        enable     = 1'b0;
        digits_bcd = 16'h0000;
        dp_mask    = '0;
        blank_mask = '0;
        blink_mask = '0;
        blink_tick = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset_values");

        // Test 1: basic scan of 1234
        rst_n      = 1'b1;
        enable     = 1'b1;
        digits_bcd = 16'h1234;
        tick       = 0;
        phase      = 1'b0;
        step();
        check("t1_ghost_slot0", anodes, 4'hF);
        step();
        check("t1_anode_slot0", anodes, 4'hE);
        check("t1_seg_4", segment, 7'b1001100);
        step();
        step();
        step();
        check("t1_ghost_slot1", anodes, 4'hF);
        step();
        check("t1_anode_slot1", anodes, 4'hD);
        check("t1_seg_3", segment, 7'b0000110);
        fd_count = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_done) fd_count++;
        end
        check("t1_frame_done_count", fd_count, 2);

        // Test 2: decimal point and blank
        dp_mask    = 4'b0100;
        blank_mask = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anodes == 4'hE) check("t2_blank_slot0", {decimal_point, segment}, {1'b1, 7'h7F});
            if (anodes == 4'hB) check("t2_dp_slot2", decimal_point, 1'b0);
        end
        dp_mask    = '0;
        blank_mask = '0;

        // Test 3: blink digits 0 and 1
        blink_mask = 4'b0011;
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anodes == 4'hE || anodes == 4'hD) check("t3_blink_dark", segment, 7'h7F);
            if (anodes == 4'hB) check("t3_digit2_lit", segment, 7'b0010010);
        end
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        for (int i = 0; i < 16; i++) step();
        blink_mask = '0;

        // Test 4: drop enable during slot 2
        guard = 0;
        while (((tick / RD) % ND) != 2 || (tick % RD) != 2) begin
            step();
            guard++;
            if (guard > 64) break;
        end
        check("t4_reached_slot2", guard <= 64, 1'b1);
        enable = 1'b0;
        step();
        check("t4_disabled_dark", {digit_sel, decimal_point, anodes, segment},
              {2'b00, 1'b1, 4'hF, 7'h7F});
        step();
        enable = 1'b1;
        step();
        check("t4_reenable_ghost", anodes, 4'hF);
        step();
        check("t4_reenable_slot0", anodes, 4'hE);

        // Test 5: hex code B in digit 0
        digits_bcd = 16'h123B;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anodes == 4'hE) begin
`ifdef SEVSEG_HEX_EN
                check("t5_hex_b", segment, 7'b1100000);
`else
                check("t5_hex_b_dark", segment, 7'h7F);
`endif
            end
        end
        digits_bcd = 16'h1234;

        // Test 6: asynchronous reset mid-slot 3
        guard = 0;
        while (((tick / RD) % ND) != 3 || (tick % RD) != 2) begin
            step();
            guard++;
            if (guard > 64) break;
        end
        check("t6_reached_slot3", guard <= 64, 1'b1);
        check("t6_slot3_lit", anodes, 4'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async_reset");
        exp_q.delete();
        tick  = 0;
        phase = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("t6_reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
